// File: rtl/obi_resp_pkg.sv
// ============================================================================
// Module   : obi_resp_pkg
// Purpose  : Shared types and constants for the OBI slave-side responder.
//            resp_tag_t  - one response slot travelling down the latency pipe
//            fsm_e       - grant-side stall tracker states
//            ERR_CNT_W   - width of the saturating error-response counter
//            MAX_RD_LATENCY - largest supported grant-to-response latency
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package obi_resp_pkg;

  localparam int ERR_CNT_W      = 16;
  localparam int MAX_RD_LATENCY = 4;

  typedef struct packed {
    logic valid;
    logic we;
    logic err;
  } resp_tag_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ABORT = 2'd2
  } fsm_e;

endpackage

`default_nettype wire

// File: rtl/obi_resp_pipe.sv
// ============================================================================
// Module   : obi_resp_pipe
// Purpose  : RD_LATENCY-deep shift register of response tags. A tag written
//            on i_tag appears on o_tag exactly RD_LATENCY clocks later.
// Ports    : clk_i  - clock
//            rst_i  - synchronous active-high clear of every stage
//            i_tag  - tag captured this cycle (valid=0 for idle cycles)
//            o_tag  - tag of the oldest stage
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_resp_pipe
  import obi_resp_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  resp_tag_t i_tag,
  output resp_tag_t o_tag
);

  resp_tag_t r_stage [RD_LATENCY];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < RD_LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[RD_LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/obi_resp_bridge.sv
// ============================================================================
// Module   : obi_resp_bridge
// Purpose  : OBI slave-side responder. Grants OBI requests, forwards them to a
//            stallable register/memory backend and returns an in-order,
//            fixed-latency response (rvalid/rdata/err). Out-of-window
//            addresses and empty byte enables are answered with an error
//            without touching the backend.
// Ports    : clk_i/rst_i            - clock, synchronous active-high reset
//            req_i/gnt_o/addr_i/we_i/be_i/wdata_i - OBI request channel
//            rvalid_o/rdata_o/err_o - OBI response channel (no backpressure)
//            reg_*                  - backend access port
//            err_cnt_o              - saturating count of error responses
// Options  : OBI_RESP_TIMEOUT_EN - when defined, a request stalled by the
//            backend is force-granted with an error after TIMEOUT_CYCLES.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module obi_resp_bridge
  import obi_resp_pkg::*;
#(
  parameter int            AW             = 32,
  parameter int            DW             = 32,
  parameter int            RD_LATENCY     = 1,
  parameter logic [AW-1:0] WIN_MASK       = AW'(32'h0000_0FFF),
  parameter int            TIMEOUT_CYCLES = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [AW-1:0]        addr_i,
  input  logic                 we_i,
  input  logic [DW/8-1:0]      be_i,
  input  logic [DW-1:0]        wdata_i,
  output logic                 rvalid_o,
  output logic [DW-1:0]        rdata_o,
  output logic                 err_o,
  output logic                 reg_req_o,
  input  logic                 reg_ready_i,
  output logic                 reg_we_o,
  output logic [AW-1:0]        reg_addr_o,
  output logic [DW/8-1:0]      reg_be_o,
  output logic [DW-1:0]        reg_wdata_o,
  input  logic [DW-1:0]        reg_rdata_i,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  // Elaboration-time guard on the supported configuration range.
  if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY ||
      TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 256) begin : g_bad_config
    $error("obi_resp_bridge: unsupported RD_LATENCY or TIMEOUT_CYCLES");
  end

  fsm_e            r_state;
  fsm_e            w_state_nxt;
  logic            w_dec_err;
  logic            w_abort;
  logic            w_timeout;
  resp_tag_t       w_tag_in;
  resp_tag_t       w_tag_out;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Decode error: any address bit outside the window, or no byte selected.
  assign w_dec_err = req_i & (((addr_i & ~WIN_MASK) != '0) | (be_i == '0));

  assign gnt_o     = req_i & (w_dec_err | reg_ready_i | w_abort);
  assign reg_req_o = req_i & ~w_dec_err & ~w_abort;

  assign reg_we_o    = we_i;
  assign reg_addr_o  = addr_i & WIN_MASK;
  assign reg_be_o    = be_i;
  assign reg_wdata_o = wdata_i;

`ifdef OBI_RESP_TIMEOUT_EN
  logic [7:0] r_wait_cnt;

  // The abort cycle is the one in which the counter would read
  // TIMEOUT_CYCLES-1, so the decision is taken one count earlier.
  assign w_timeout = (r_wait_cnt == 8'(TIMEOUT_CYCLES - 2));
  assign w_abort   = (r_state == ABORT);

  always_ff @(posedge clk_i) begin
    if (rst_i || r_state != WAIT) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_abort   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (req_i & ~gnt_o) w_state_nxt = WAIT;
      end
      WAIT: begin
        // A dropped request is tolerated and simply ends the stall.
        if (gnt_o | ~req_i)  w_state_nxt = IDLE;
        else if (w_timeout)  w_state_nxt = ABORT;
      end
      ABORT:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // gnt_o already implies req_i, so it is the accept strobe.
  assign w_tag_in = '{valid: gnt_o, we: we_i, err: w_dec_err | w_abort};

  obi_resp_pipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign rvalid_o = w_tag_out.valid;
  assign err_o    = w_tag_out.err & w_tag_out.valid;
  assign rdata_o  = (w_tag_out.valid & ~w_tag_out.we & ~w_tag_out.err) ?
                    reg_rdata_i : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err_cnt <= '0;
    end else if (rvalid_o && err_o && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign err_cnt_o = r_err_cnt;

endmodule

`default_nettype wire
